sample_packetizer: RTL and testbench
====================================

Name: sample_packetizer

Overview:
- Upstream stage of the split/loopback compute-engine blocks.
- Takes a raw 32-bit sample AXI stream with a sideband end-of-burst flag and chops it into packets of programmable samples-per-packet (SPP), driving tlast for the downstream chdr_framer.
- A one-sample hold register lets a packet close early on burst end or on an input idle timeout.
- Per-port packet statistics are exposed for readback registers.

Parameters:
WIDTH, 32, sample width in bits
SPP_WIDTH, 16, width of spp input and internal sample index
TIMEOUT_WIDTH, 16, width of timeout input and idle timer

Ports:
ce_clk  in  1  compute-engine clock; all logic on rising edge
ce_rst  in  1  reset, asynchronous, active-high
clear  in  1  synchronous flush of packet state and counters
spp  in  SPP_WIDTH  samples per packet; 0 treated as 1
timeout  in  TIMEOUT_WIDTH  idle cycles before forced tlast; 0 disables
i_tdata  in  WIDTH  input sample
i_teob  in  1  sample is last of burst
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  WIDTH  output sample
o_tlast  out  1  last sample of packet
o_teob  out  1  last sample of burst (only with o_tlast)
o_tvalid  out  1  output valid
o_tready  in  1  output ready
pkt_count  out  32  packets emitted (tlast handshakes)
short_pkt_count  out  32  packets closed with fewer than SPP samples

Behaviour:
- State: hold_valid, hold_data, hold_eob, hold_final, timed_out, idx (samples in current packet incl. held), spp_latched, idle timer.
- Reset (ce_rst async): all state 0; i_tready=1, o_tvalid=0, o_tlast=0, o_teob=0, both counters 0.
- clear (sync, priority over all else): same as reset; held sample dropped, no output.
- Input acceptance: i_tready = ~hold_valid | (o_tvalid & o_tready). On accept: sample → hold_data; idx increments (or becomes 1 if previous packet just closed); idle timer cleared, timed_out cleared.
- SPP latched when the first sample of a packet is accepted (idx 0→1); mid-packet spp changes take effect at the next packet.
- hold_final set at capture when idx_new == spp_latched or i_teob=1.
- Output: o_tvalid = hold_valid & (i_tvalid | hold_final | timed_out). o_tdata = hold_data. o_tlast = hold_final | timed_out. o_teob = hold_eob & o_tlast.
- Streaming throughput: 1 sample/cycle. A non-final held sample is emitted in the cycle the next sample is presented. A final sample is emitted the cycle after capture.
- Idle timer:
  - Counts while hold_valid & ~hold_final & ~timed_out & ~i_tvalid & timeout≠0.
  - Reset whenever i_tvalid=1 or on any accept.
  - When the count reaches timeout, timed_out is set on the next edge.
  - Once set, o_tlast=1 is committed and held stable until the handshake, even if i_tvalid rises.
  - A sample arriving the same cycle the timer would expire wins: no timeout, and the held sample is emitted non-last.
- On tlast handshake: idx→0 (or 1 if a new sample is accepted in the same cycle; it is the first sample of the new packet); pkt_count+1. short_pkt_count+1 if idx<spp_latched at close (eob or timeout).
- Counters wrap modulo 2^32.
- spp=1 or 0: every sample final; a held sample never waits for a successor.
- AXI rules: o_tdata/o_tlast/o_teob stable while o_tvalid & ~o_tready. No combinational path from o_tready to o_tvalid.

Test Plan:
- Reset then spp=4, timeout=0, stream 0..11 back-to-back with o_tready=1 → 3 packets; tlast on samples 3,7,11; sample 11 one cycle after capture; pkt_count=3, short=0.
- spp=4, samples 0..5 with i_teob on 5 → tlast on 3 and on 5; o_teob only on 5; pkt_count=2, short=1.
- spp=8, timeout=10, send 3 samples then idle → sample 2 held, emitted with tlast exactly 11 cycles after its capture; short=1. Repeat with new sample on expiry cycle → no tlast.
- spp=4, o_tready toggled 1/0 randomly over 400 samples → data order preserved, tdata/tlast stable while stalled, tlast every 4th sample, pkt_count=100.
- Change spp 4→2 after 2nd sample of a packet → current packet 4 samples, next packets 2.
- Assert clear with sample held, then ce_rst mid-packet → no output for dropped sample; counters 0; next packet restarts at idx 1.

Source files
------------

// File: rtl/sample_packetizer.sv
// rtl/sample_packetizer.sv - chops a raw sample stream into SPP-sized packets with eob/timeout early close
module sample_packetizer #(
  parameter int WIDTH         = 32,
  parameter int SPP_WIDTH     = 16,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     ce_clk,
  input  logic                     ce_rst,
  input  logic                     clear,
  input  logic [SPP_WIDTH-1:0]     spp,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic [WIDTH-1:0]         i_tdata,
  input  logic                     i_teob,
  input  logic                     i_tvalid,
  output logic                     i_tready,
  output logic [WIDTH-1:0]         o_tdata,
  output logic                     o_tlast,
  output logic                     o_teob,
  output logic                     o_tvalid,
  input  logic                     o_tready,
  output logic [31:0]              pkt_count,
  output logic [31:0]              short_pkt_count
);

  logic                     hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0]         hold_data_q, hold_data_d;
  logic                     hold_eob_q, hold_eob_d;
  logic                     hold_final_q, hold_final_d;
  logic                     timed_out_q, timed_out_d;
  logic [SPP_WIDTH-1:0]     idx_q, idx_d;
  logic [SPP_WIDTH-1:0]     spp_q, spp_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic [31:0]              pkt_count_q, pkt_count_d;
  logic [31:0]              short_q, short_d;

  logic                     out_hs, accept, close;
  logic [SPP_WIDTH-1:0]     spp_eff, spp_cur, idx_base, idx_new;
  logic [TIMEOUT_WIDTH-1:0] timer_inc;

  assign spp_eff  = (spp == '0) ? SPP_WIDTH'(1) : spp;
  // A non-final held sample is only released once its successor shows up,
  // so the successor decides whether it was last.
  assign o_tvalid = hold_valid_q & ~clear & (i_tvalid | hold_final_q | timed_out_q);
  assign o_tdata  = hold_data_q;
  assign o_tlast  = hold_final_q | timed_out_q;
  assign o_teob   = hold_eob_q & o_tlast;
  assign out_hs   = o_tvalid & o_tready;
  assign i_tready = ~hold_valid_q | out_hs;
  assign accept   = i_tvalid & i_tready;
  assign close    = out_hs & o_tlast;

  assign idx_base  = close ? '0 : idx_q;
  assign idx_new   = idx_base + SPP_WIDTH'(1);
  assign spp_cur   = (idx_base == '0) ? spp_eff : spp_q;
  assign timer_inc = timer_q + TIMEOUT_WIDTH'(1);

  assign pkt_count       = pkt_count_q;
  assign short_pkt_count = short_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_eob_d   = hold_eob_q;
    hold_final_d = hold_final_q;
    timed_out_d  = timed_out_q;
    idx_d        = idx_q;
    spp_d        = spp_q;
    timer_d      = timer_q;
    pkt_count_d  = pkt_count_q;
    short_d      = short_q;

    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = i_tdata;
      hold_eob_d   = i_teob;
      hold_final_d = (idx_new == spp_cur) | i_teob;
      timed_out_d  = 1'b0;
      idx_d        = idx_new;
      if (idx_base == '0) spp_d = spp_cur;
    end else if (out_hs) begin
      hold_valid_d = 1'b0;
      hold_eob_d   = 1'b0;
      hold_final_d = 1'b0;
      timed_out_d  = 1'b0;
      idx_d        = idx_base;
    end

    // Any upstream activity restarts the idle window; a sample in the
    // expiry cycle therefore beats the timeout.
    if (i_tvalid | ~hold_valid_q) begin
      timer_d = '0;
    end else if (~hold_final_q & ~timed_out_q & (timeout != '0)) begin
      timer_d = timer_inc;
      if (timer_inc == timeout) timed_out_d = 1'b1;
    end

    if (close) begin
      pkt_count_d = pkt_count_q + 32'd1;
      if (idx_q < spp_q) short_d = short_q + 32'd1;
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_eob_q   <= 1'b0;
      hold_final_q <= 1'b0;
      timed_out_q  <= 1'b0;
      idx_q        <= '0;
      spp_q        <= '0;
      timer_q      <= '0;
      pkt_count_q  <= '0;
      short_q      <= '0;
    end else if (clear) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_eob_q   <= 1'b0;
      hold_final_q <= 1'b0;
      timed_out_q  <= 1'b0;
      idx_q        <= '0;
      spp_q        <= '0;
      timer_q      <= '0;
      pkt_count_q  <= '0;
      short_q      <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_eob_q   <= hold_eob_d;
      hold_final_q <= hold_final_d;
      timed_out_q  <= timed_out_d;
      idx_q        <= idx_d;
      spp_q        <= spp_d;
      timer_q      <= timer_d;
      pkt_count_q  <= pkt_count_d;
      short_q      <= short_d;
    end
  end

endmodule

// File: tb/tb_sample_packetizer.sv
// tb/tb_sample_packetizer.sv - self-checking bench for sample_packetizer
module tb_sample_packetizer;
  localparam int W  = 32;
  localparam int SW = 16;
  localparam int TW = 16;

  logic          ce_clk = 1'b0;
  logic          ce_rst = 1'b1;
  logic          clear = 1'b0;
  logic [SW-1:0] spp = 16'd4;
  logic [TW-1:0] timeout = '0;
  logic [W-1:0]  i_tdata = '0;
  logic          i_teob = 1'b0;
  logic          i_tvalid = 1'b0;
  logic          i_tready;
  logic [W-1:0]  o_tdata;
  logic          o_tlast, o_teob, o_tvalid;
  logic          o_tready = 1'b1;
  logic [31:0]   pkt_count, short_pkt_count;

  sample_packetizer #(.WIDTH(W), .SPP_WIDTH(SW), .TIMEOUT_WIDTH(TW)) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear), .spp(spp), .timeout(timeout),
    .i_tdata(i_tdata), .i_teob(i_teob), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_teob(o_teob), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .pkt_count(pkt_count), .short_pkt_count(short_pkt_count)
  );

  always #5 ce_clk = ~ce_clk;

  int cyc = 0;
  always @(posedge ce_clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    logic         e;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0, n_fail = 0;
  int   m_cnt = 0, m_lat = 1, exp_pkt = 0, exp_short = 0;
  int   last_cap_cyc = 0, last_tlast_hs = 0, last_hs = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet model: a packet ends when it holds its latched SPP or on a burst end.
  task automatic model_push(input logic [W-1:0] d, input bit eob);
    exp_t e;
    if (m_cnt == 0) m_lat = (spp == 0) ? 1 : int'(spp);
    m_cnt++;
    e.d = d;
    e.l = (m_cnt == m_lat) || eob;
    e.e = eob;
    exp_q.push_back(e);
    if (e.l) begin
      exp_pkt++;
      if (m_cnt < m_lat) exp_short++;
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    exp_pkt = 0;
    exp_short = 0;
  endtask

  task automatic send(input logic [W-1:0] d, input bit eob);
    bit rdy;
    int n = 0;
    model_push(d, eob);
    i_tdata  = d;
    i_teob   = eob;
    i_tvalid = 1'b1;
    do begin
      @(negedge ce_clk);
      rdy = i_tready;
      @(posedge ce_clk);
      #1;
      n++;
    end while (!rdy && n < 1000);
    if (!rdy) chk("send_bound", 0, 1);
    last_cap_cyc = cyc;
    i_tvalid = 1'b0;
    i_teob   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ce_clk);
      #1;
    end
  endtask

  task automatic drain_and_count(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      idle(1);
      n++;
    end
    idle(1);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_pkt"}, pkt_count, exp_pkt);
    chk({tag, "_short"}, short_pkt_count, exp_short);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    model_reset();
  endtask

  initial begin
    forever begin
      @(posedge ce_clk);
      #1;
      o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on handshakes, stability check on stalls.
  bit           stalled = 1'b0;
  logic [W-1:0] pd;
  logic         pl, pe;
  always @(negedge ce_clk) begin
    exp_t e;
    if (!ce_rst && !clear) begin
      if (stalled) begin
        chk("stall_valid", o_tvalid, 1);
        chk("stall_data", o_tdata, pd);
        chk("stall_last", {o_tlast, o_teob}, {pl, pe});
      end
      if (o_tvalid && o_tready) begin
        last_hs = cyc + 1;
        if (o_tlast) last_tlast_hs = cyc + 1;
        if (exp_q.size() == 0) chk("unexpected_out", o_tdata, 'x);
        else begin
          e = exp_q.pop_front();
          chk("tdata", o_tdata, e.d);
          chk("tlast", o_tlast, e.l);
          chk("teob", o_teob, e.e);
        end
      end
      stalled = o_tvalid && !o_tready;
      pd = o_tdata;
      pl = o_tlast;
      pe = o_teob;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    idle(2);
    chk("rst_tready", i_tready, 1);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tlast", o_tlast, 0);
    chk("rst_teob", o_teob, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_short", short_pkt_count, 0);
    ce_rst = 1'b0;
    idle(1);

    spp = 16'd4;
    timeout = '0;
    for (int i = 0; i < 12; i++) send(W'(i), 1'b0);
    c0 = last_cap_cyc;
    drain_and_count("t1");
    chk("t1_final_latency", last_tlast_hs - c0, 1);

    do_clear();
    for (int i = 0; i < 6; i++) send(W'(i), i == 5);
    drain_and_count("t2");

    do_clear();
    spp = 16'd8;
    timeout = 16'd10;
    for (int i = 0; i < 3; i++) send(W'(32'hA0 + i), 1'b0);
    c0 = last_cap_cyc;
    exp_q[exp_q.size()-1].l = 1'b1;
    exp_pkt++;
    exp_short++;
    m_cnt = 0;
    idle(20);
    chk("t3_timeout_latency", last_tlast_hs - c0, 11);
    chk("t3_pkt", pkt_count, exp_pkt);
    chk("t3_short", short_pkt_count, exp_short);

    for (int i = 0; i < 3; i++) send(W'(32'hB0 + i), 1'b0);
    c0 = last_cap_cyc;
    idle(9);
    send(32'hB3, 1'b1);
    chk("t3b_beat_timer_hs", last_hs - c0, 10);
    drain_and_count("t3b");
    timeout = '0;

    do_clear();
    spp = 16'd4;
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send($urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain_and_count("t4");
    chk("t4_pkt100", pkt_count, 100);
    rand_ready = 1'b0;

    do_clear();
    spp = 16'd4;
    send(32'h10, 1'b0);
    send(32'h11, 1'b0);
    spp = 16'd2;
    for (int i = 2; i < 8; i++) send(W'(32'h10 + i), 1'b0);
    drain_and_count("t5");
    chk("t5_pkt3", pkt_count, 3);

    do_clear();
    spp = 16'd4;
    send(32'h100, 1'b0);
    idle(3);
    chk("t6_held_not_out", exp_q.size(), 1);
    do_clear();
    chk("t6_clr_pkt", pkt_count, 0);
    chk("t6_clr_tvalid", o_tvalid, 0);
    chk("t6_clr_tready", i_tready, 1);
    for (int i = 0; i < 4; i++) send(W'(32'h200 + i), 1'b0);
    drain_and_count("t6a");
    send(32'h300, 1'b0);
    send(32'h301, 1'b0);
    #3;
    ce_rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", o_tvalid, 0);
    chk("t6_rst_pkt", pkt_count, 0);
    chk("t6_rst_short", short_pkt_count, 0);
    chk("t6_rst_tready", i_tready, 1);
    model_reset();
    idle(1);
    ce_rst = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) send(W'(32'h400 + i), 1'b0);
    drain_and_count("t6b");
    chk("t6b_pkt1", pkt_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
